// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback for the datapath.
// Latency (mem_ready=1): ALU op 4 cycles, branch 3, store 4, load 5; outputs combinational from state and ir.
// Backpressure: FETCH and MEM hold mem_req until mem_ready; optional illegal trap via RV32I_ILLEGAL_TRAP_EN.
module rv32i_multicycle_ctrl #(
    parameter int RESET_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        alu_zero,
    input  logic        alu_lsb,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        asel,
    output logic        bsel,
    output logic [2:0]  immsel,
    output logic [4:0]  alu_ctrl,
    output logic        aluout_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_PASSB = 5'd10;

    localparam logic [3:0] WAIT_N = 4'(RESET_WAIT);

    state_t     state, state_n;
    logic [3:0] wait_cnt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       taken;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign alt       = ir[30];
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    // funct3 (+ funct7[5]) to ALU operation; SUB only exists for register-register ops
    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic f7b5, input logic is_reg);
        case (f3)
            3'd0:    return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Branch outcome from the ALU flags; undefined funct3 values fall through as not taken
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'd0:    taken = alu_zero;
            3'd1:    taken = !alu_zero;
            3'd4,
            3'd6:    taken = alu_lsb;
            3'd5,
            3'd7:    taken = !alu_lsb;
            default: taken = 1'b0;
        endcase
    end

`ifdef RV32I_ILLEGAL_TRAP_EN
    logic illegal;
    logic trap_q;

    // Opcode/funct3 legality, only consulted in EXEC
    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL: illegal = 1'b0;
            OP_LOAD:   illegal = (funct3 == 3'd3) || (funct3 >= 3'd6);
            OP_STORE:  illegal = (funct3 > 3'd2);
            OP_BRANCH: illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            OP_JALR:   illegal = (funct3 != 3'd0);
            default:   illegal = 1'b1;
        endcase
    end

    // Sticky trap flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) trap_q <= 1'b0;
        else       trap_q <= (state_n == S_TRAP);
    end
`endif

    // State register and post-reset idle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_RESET;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_n;
            if (state == S_RESET && wait_cnt != WAIT_N) wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Next state and datapath controls; everything forced to 0 while reset is high
    always_comb begin
        state_n      = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        immsel       = 3'd0;
        alu_ctrl     = ALU_ADD;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        retire       = 1'b0;
        trap         = 1'b0;
        if (!reset) begin
`ifdef RV32I_ILLEGAL_TRAP_EN
            trap = trap_q;
`endif
            case (state)
                S_RESET: if (wait_cnt == WAIT_N) state_n = S_FETCH;
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_n  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Precompute OldPC + Imm as the branch/JAL target
                    asel         = 1'b1;
                    bsel         = 1'b1;
                    immsel       = (opcode == OP_JAL) ? 3'd4 : 3'd2;
                    aluout_write = 1'b1;
                    state_n      = S_EXEC;
                end
                S_EXEC: begin
`ifdef RV32I_ILLEGAL_TRAP_EN
                    if (illegal) state_n = S_TRAP;
                    else
`endif
                    begin
                        case (opcode)
                            OP_REG: begin
                                alu_ctrl     = alu_from_f3(funct3, alt, 1'b1);
                                aluout_write = 1'b1;
                                state_n      = S_WB;
                            end
                            OP_IMM: begin
                                bsel         = 1'b1;
                                alu_ctrl     = alu_from_f3(funct3, alt, 1'b0);
                                aluout_write = 1'b1;
                                state_n      = S_WB;
                            end
                            OP_LOAD, OP_STORE: begin
                                bsel         = 1'b1;
                                immsel       = (opcode == OP_STORE) ? 3'd1 : 3'd0;
                                aluout_write = 1'b1;
                                state_n      = S_MEM;
                            end
                            OP_BRANCH: begin
                                alu_ctrl = (funct3[2:1] == 2'b00) ? ALU_SUB :
                                           (funct3[1] ? ALU_SLTU : ALU_SLT);
                                pc_write = taken;
                                pc_src   = taken;
                                retire   = 1'b1;
                                state_n  = S_FETCH;
                            end
                            OP_JAL: begin
                                pc_write = 1'b1;
                                pc_src   = 1'b1;
                                state_n  = S_WB;
                            end
                            OP_JALR: begin
                                bsel     = 1'b1;
                                pc_write = 1'b1;
                                pc_src   = 1'b1;
                                state_n  = S_WB;
                            end
                            OP_LUI, OP_AUIPC: begin
                                asel         = (opcode == OP_AUIPC);
                                bsel         = 1'b1;
                                immsel       = 3'd3;
                                alu_ctrl     = (opcode == OP_LUI) ? ALU_PASSB : ALU_ADD;
                                aluout_write = 1'b1;
                                state_n      = S_WB;
                            end
                            default: begin
                                retire  = 1'b1;
                                state_n = S_FETCH;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (opcode == OP_STORE);
                    if (mem_ready) begin
                        if (opcode == OP_STORE) begin
                            retire  = 1'b1;
                            state_n = S_FETCH;
                        end else begin
                            state_n = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    wb_sel    = (opcode == OP_LOAD) ? 2'd1 :
                                ((opcode == OP_JAL || opcode == OP_JALR) ? 2'd2 : 2'd0);
                    state_n   = S_FETCH;
                end
                default: state_n = S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: cycle-by-cycle vector table plus stall and reset sequences.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// A second instance with RESET_WAIT=3 shares all inputs and is checked only around reset.
module tb_rv32i_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        zero, lsb, rdy;

    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, asel, bsel;
    logic [2:0]  immsel;
    logic [4:0]  alu_ctrl;
    logic        aluout_write, reg_write, retire, trap;
    logic [1:0]  wb_sel;

    logic        mem_req3, mem_we3, addr_sel3, ir_write3, pc_write3, pc_src3, asel3, bsel3;
    logic [2:0]  immsel3;
    logic [4:0]  alu_ctrl3;
    logic        aluout_write3, reg_write3, retire3, trap3;
    logic [1:0]  wb_sel3;

    rv32i_multicycle_ctrl dut (
        .clock(clk), .reset(rst), .ir(ir), .alu_zero(zero), .alu_lsb(lsb), .mem_ready(rdy),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .asel(asel), .bsel(bsel), .immsel(immsel),
        .alu_ctrl(alu_ctrl), .aluout_write(aluout_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .retire(retire), .trap(trap)
    );

    rv32i_multicycle_ctrl #(.RESET_WAIT(3)) dut3 (
        .clock(clk), .reset(rst), .ir(ir), .alu_zero(zero), .alu_lsb(lsb), .mem_ready(rdy),
        .mem_req(mem_req3), .mem_we(mem_we3), .addr_sel(addr_sel3), .ir_write(ir_write3),
        .pc_write(pc_write3), .pc_src(pc_src3), .asel(asel3), .bsel(bsel3), .immsel(immsel3),
        .alu_ctrl(alu_ctrl3), .aluout_write(aluout_write3), .reg_write(reg_write3),
        .wb_sel(wb_sel3), .retire(retire3), .trap(trap3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] ir;
        logic        z;
        logic        lsb;
        logic        rdy;
        logic [21:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nerr = 0;

    // Expected-output packer: mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
    // asel, bsel, immsel, alu_ctrl, aluout_write, reg_write, wb_sel, retire, trap
    function automatic logic [21:0] mk(input logic rq, input logic we, input logic ad,
            input logic irw, input logic pcw, input logic pcs, input logic a, input logic b,
            input logic [2:0] im, input logic [4:0] al, input logic aow, input logic rw,
            input logic [1:0] wb, input logic ret, input logic tr);
        return {rq, we, ad, irw, pcw, pcs, a, b, im, al, aow, rw, wb, ret, tr};
    endfunction

    function automatic logic [21:0] outs();
        return {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, asel, bsel, immsel,
                alu_ctrl, aluout_write, reg_write, wb_sel, retire, trap};
    endfunction

    task automatic add(input logic r, input logic [31:0] i, input logic z, input logic l,
                       input logic rd, input logic [21:0] e, input string n);
        vec_t v;
        v.rst = r; v.ir = i; v.z = z; v.lsb = l; v.rdy = rd; v.exp = e; v.name = n;
        vq.push_back(v);
    endtask

    task automatic check(input string n, input logic [21:0] got, input logic [21:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [31:0] i, input logic z, input logic l,
                         input logic rd, input logic [21:0] e, input string n);
        rst = r; ir = i; zero = z; lsb = l; rdy = rd;
        #1;
        check(n, outs(), e);
        @(negedge clk);
    endtask

    localparam logic [31:0] ADDI  = 32'h00500093, BEQ  = 32'h00000463, JAL   = 32'h008000EF;
    localparam logic [31:0] SW    = 32'h0020A223, SUB  = 32'h402081B3, SRAI  = 32'h4030D093;
    localparam logic [31:0] LUI   = 32'h123452B7, AUIPC = 32'h00001117, JALR = 32'h000080E7;
    localparam logic [31:0] BLTU  = 32'h0020E463, BGE  = 32'h0020D463, LW    = 32'h0000A103;
    localparam logic [31:0] ILL   = 32'hFFFFFFFF;

    logic [21:0] ZZ, F1, F0, DB, DJ, WB0, WB1, WB2, LDX, MRD;

    initial begin
        ZZ  = '0;
        F1  = mk(1,0,0,1,1,0, 0,0,3'd0,5'd0,0,0,2'd0,0,0);
        F0  = mk(1,0,0,0,0,0, 0,0,3'd0,5'd0,0,0,2'd0,0,0);
        DB  = mk(0,0,0,0,0,0, 1,1,3'd2,5'd0,1,0,2'd0,0,0);
        DJ  = mk(0,0,0,0,0,0, 1,1,3'd4,5'd0,1,0,2'd0,0,0);
        WB0 = mk(0,0,0,0,0,0, 0,0,3'd0,5'd0,0,1,2'd0,1,0);
        WB1 = mk(0,0,0,0,0,0, 0,0,3'd0,5'd0,0,1,2'd1,1,0);
        WB2 = mk(0,0,0,0,0,0, 0,0,3'd0,5'd0,0,1,2'd2,1,0);
        LDX = mk(0,0,0,0,0,0, 0,1,3'd0,5'd0,1,0,2'd0,0,0);
        MRD = mk(1,0,1,0,0,0, 0,0,3'd0,5'd0,0,0,2'd0,0,0);

        add(1, ADDI, 0,0,1, ZZ,  "reset");
        add(0, ADDI, 0,0,1, ZZ,  "reset_idle");
        add(0, ADDI, 0,0,1, F1,  "addi_fetch");
        add(0, ADDI, 0,0,0, DB,  "addi_decode");
        add(0, ADDI, 0,0,1, mk(0,0,0,0,0,0, 0,1,3'd0,5'd0,1,0,2'd0,0,0), "addi_exec");
        add(0, ADDI, 0,0,1, WB0, "addi_wb");
        add(0, BEQ,  0,0,0, F0,  "beq_fetch_stall");
        add(0, BEQ,  0,0,1, F1,  "beq_fetch");
        add(0, BEQ,  1,0,1, DB,  "beq_decode");
        add(0, BEQ,  1,0,1, mk(0,0,0,0,1,1, 0,0,3'd0,5'd1,0,0,2'd0,1,0), "beq_taken");
        add(0, BEQ,  0,0,1, F1,  "beq2_fetch");
        add(0, BEQ,  0,0,1, DB,  "beq2_decode");
        add(0, BEQ,  0,0,1, mk(0,0,0,0,0,0, 0,0,3'd0,5'd1,0,0,2'd0,1,0), "beq_not_taken");
        add(0, JAL,  0,0,1, F1,  "jal_fetch");
        add(0, JAL,  0,0,1, DJ,  "jal_decode");
        add(0, JAL,  0,0,1, mk(0,0,0,0,1,1, 0,0,3'd0,5'd0,0,0,2'd0,0,0), "jal_exec");
        add(0, JAL,  0,0,1, WB2, "jal_wb");
        add(0, SW,   0,0,1, F1,  "sw_fetch");
        add(0, SW,   0,0,1, DB,  "sw_decode");
        add(0, SW,   0,0,1, mk(0,0,0,0,0,0, 0,1,3'd1,5'd0,1,0,2'd0,0,0), "sw_exec");
        add(0, SW,   0,0,1, mk(1,1,1,0,0,0, 0,0,3'd0,5'd0,0,0,2'd0,1,0), "sw_mem");
        add(0, SUB,  0,0,1, F1,  "sub_fetch");
        add(0, SUB,  0,0,1, DB,  "sub_decode");
        add(0, SUB,  0,0,1, mk(0,0,0,0,0,0, 0,0,3'd0,5'd1,1,0,2'd0,0,0), "sub_exec");
        add(0, SUB,  0,0,1, WB0, "sub_wb");
        add(0, SRAI, 0,0,1, F1,  "srai_fetch");
        add(0, SRAI, 0,0,1, DB,  "srai_decode");
        add(0, SRAI, 0,0,1, mk(0,0,0,0,0,0, 0,1,3'd0,5'd7,1,0,2'd0,0,0), "srai_exec");
        add(0, SRAI, 0,0,1, WB0, "srai_wb");
        add(0, LUI,  0,0,1, F1,  "lui_fetch");
        add(0, LUI,  0,0,1, DB,  "lui_decode");
        add(0, LUI,  0,0,1, mk(0,0,0,0,0,0, 0,1,3'd3,5'd10,1,0,2'd0,0,0), "lui_exec");
        add(0, LUI,  0,0,1, WB0, "lui_wb");
        add(0, AUIPC,0,0,1, F1,  "auipc_fetch");
        add(0, AUIPC,0,0,1, DB,  "auipc_decode");
        add(0, AUIPC,0,0,1, mk(0,0,0,0,0,0, 1,1,3'd3,5'd0,1,0,2'd0,0,0), "auipc_exec");
        add(0, AUIPC,0,0,1, WB0, "auipc_wb");
        add(0, JALR, 0,0,1, F1,  "jalr_fetch");
        add(0, JALR, 0,0,1, DB,  "jalr_decode");
        add(0, JALR, 0,0,1, mk(0,0,0,0,1,1, 0,1,3'd0,5'd0,0,0,2'd0,0,0), "jalr_exec");
        add(0, JALR, 0,0,1, WB2, "jalr_wb");
        add(0, BLTU, 0,1,1, F1,  "bltu_fetch");
        add(0, BLTU, 0,1,1, DB,  "bltu_decode");
        add(0, BLTU, 0,1,1, mk(0,0,0,0,1,1, 0,0,3'd0,5'd4,0,0,2'd0,1,0), "bltu_taken");
        add(0, BGE,  0,1,1, F1,  "bge_fetch");
        add(0, BGE,  0,1,1, DB,  "bge_decode");
        add(0, BGE,  0,1,1, mk(0,0,0,0,0,0, 0,0,3'd0,5'd3,0,0,2'd0,1,0), "bge_not_taken");
        add(0, ILL,  0,0,1, F1,  "ill_fetch");
        add(0, ILL,  0,0,1, DB,  "ill_decode");
`ifdef RV32I_ILLEGAL_TRAP_EN
        add(0, ILL,  0,0,1, ZZ,  "ill_exec");
        add(0, ILL,  0,0,1, mk(0,0,0,0,0,0, 0,0,3'd0,5'd0,0,0,2'd0,0,1), "trap_set");
        add(0, ILL,  0,0,1, mk(0,0,0,0,0,0, 0,0,3'd0,5'd0,0,0,2'd0,0,1), "trap_sticky");
`else
        add(0, ILL,  0,0,1, mk(0,0,0,0,0,0, 0,0,3'd0,5'd0,0,0,2'd0,1,0), "ill_exec_nop");
        add(0, ILL,  0,0,0, F0,  "ill_then_fetch");
`endif

        rst = 1'b1; ir = ADDI; zero = 1'b0; lsb = 1'b0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        foreach (vq[k]) apply(vq[k].rst, vq[k].ir, vq[k].z, vq[k].lsb, vq[k].rdy, vq[k].exp, vq[k].name);

        // Load with three stall cycles in MEM
        apply(1, LW, 0,0,0, ZZ,  "lw_reset");
        apply(0, LW, 0,0,0, ZZ,  "lw_reset_idle");
        apply(0, LW, 0,0,1, F1,  "lw_fetch");
        apply(0, LW, 0,0,1, DB,  "lw_decode");
        apply(0, LW, 0,0,1, LDX, "lw_exec");
        for (int s = 0; s < 3; s++) apply(0, LW, 0,0,0, MRD, "lw_mem_stall");
        apply(0, LW, 0,0,1, MRD, "lw_mem_ready");
        apply(0, LW, 0,0,1, WB1, "lw_wb");

        // Reset arriving while a load request is pending in MEM
        apply(0, LW, 0,0,1, F1,  "lw2_fetch");
        apply(0, LW, 0,0,1, DB,  "lw2_decode");
        apply(0, LW, 0,0,1, LDX, "lw2_exec");
        apply(0, LW, 0,0,0, MRD, "lw2_mem_pending");
        apply(1, LW, 0,0,0, ZZ,  "reset_mid_mem");
        for (int c = 0; c < 6; c++) begin
            rst = 1'b0; rdy = 1'b0;
            #1;
            check("post_reset_wait0", outs(), (c == 0) ? ZZ : F0);
            check("post_reset_wait3_req", {21'd0, mem_req3}, (c < 4) ? 22'd0 : 22'd1);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
